// File: rtl/direct_mapped_cache_ctrl.sv
// Read-only direct-mapped cache: CPU word reads, 128-bit block refill from MainMemory on a miss.
// Latency: hit 2 cycles after the request edge, miss 2+MEM_LATENCY; requests only accepted while idle (busy=1 otherwise).
module direct_mapped_cache_ctrl #(
   parameter int INDEX_BITS  = 10,
   parameter int MEM_LATENCY = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpuReq,
   input  logic [14:0]            cpuAddress,
   output logic [31:0]            cpuData,
   output logic                   cpuReady,
   output logic                   cpuHit,
   output logic                   busy,
   output logic [12:0]            memAddress,
   input  logic [127:0]           memData,
   output logic [COUNT_WIDTH-1:0] hitCount,
   output logic [COUNT_WIDTH-1:0] missCount
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 13 - INDEX_BITS;
   localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_COMPARE,
      S_FETCH
   } state_e;

   state_e                 state_q, state_d;
   logic [14:0]            addr_q, addr_d;
   logic [7:0]             lat_cnt_q, lat_cnt_d;
   logic [31:0]            data_q, data_d;
   logic                   ready_q, ready_d;
   logic                   hit_q, hit_d;
   logic [12:0]            mem_addr_q, mem_addr_d;
   logic [COUNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
   logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
   logic [LINES-1:0]       valid_q, valid_d;

   logic [TAG_BITS-1:0]    tag_mem  [LINES];
   logic [127:0]           line_mem [LINES];
   logic [TAG_BITS-1:0]    rd_tag_q;
   logic [127:0]           rd_line_q;
   logic                   rd_valid_q;

   logic [1:0]             addr_off;
   logic [INDEX_BITS-1:0]  addr_idx;
   logic [TAG_BITS-1:0]    addr_tag;
   logic                   fill_done;

   assign addr_off  = addr_q[1:0];
   assign addr_idx  = addr_q[INDEX_BITS+1:2];
   assign addr_tag  = addr_q[14:INDEX_BITS+2];
   assign fill_done = (state_q == S_FETCH) && (lat_cnt_q == LAT_LAST);

   // Word offset 0 sits in the most significant slice of a line.
   function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] off);
      logic [31:0] w;
      case (off)
         2'd0:    w = line[127:96];
         2'd1:    w = line[95:64];
         2'd2:    w = line[63:32];
         default: w = line[31:0];
      endcase
      return w;
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lat_cnt_d  = lat_cnt_q;
      data_d     = data_q;
      ready_d    = 1'b0;
      hit_d      = hit_q;
      mem_addr_d = mem_addr_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      valid_d    = valid_q;
      case (state_q)
         S_IDLE: begin
            if (cpuReq) begin
               addr_d  = cpuAddress;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = S_COMPARE;
         end
         S_COMPARE: begin
            if (rd_valid_q && (rd_tag_q == addr_tag)) begin
               data_d    = sel_word(rd_line_q, addr_off);
               ready_d   = 1'b1;
               hit_d     = 1'b1;
               hit_cnt_d = hit_cnt_q + COUNT_WIDTH'(1);
               state_d   = S_IDLE;
            end else begin
               miss_cnt_d = miss_cnt_q + COUNT_WIDTH'(1);
               mem_addr_d = addr_q[14:2];
               lat_cnt_d  = 8'd0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            if (fill_done) begin
               valid_d[addr_idx] = 1'b1;
               data_d            = sel_word(memData, addr_off);
               ready_d           = 1'b1;
               hit_d             = 1'b0;
               state_d           = S_IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         lat_cnt_q  <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         hit_q      <= 1'b0;
         mem_addr_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         lat_cnt_q  <= lat_cnt_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         hit_q      <= hit_d;
         mem_addr_q <= mem_addr_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         valid_q    <= valid_d;
      end
   end

   // Storage arrays are unreset; an async reset forces IDLE so an in-flight fill never writes.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_mem[addr_idx]  <= addr_tag;
         line_mem[addr_idx] <= memData;
      end
      if (state_q == S_LOOKUP) begin
         rd_tag_q   <= tag_mem[addr_idx];
         rd_line_q  <= line_mem[addr_idx];
         rd_valid_q <= valid_q[addr_idx];
      end
   end

   assign cpuData    = data_q;
   assign cpuReady   = ready_q;
   assign cpuHit     = hit_q;
   assign busy       = (state_q != S_IDLE);
   assign memAddress = mem_addr_q;
   assign hitCount   = hit_cnt_q;
   assign missCount  = miss_cnt_q;

endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// Directed bench: default instance (MEM_LATENCY=4) plus a MEM_LATENCY=1, 2-bit-counter instance for wrap.
module tb_direct_mapped_cache_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [14:0]  addr0 = '0, addr1 = '0;
   logic [31:0]  o0_dat, o1_dat;
   logic         o0_rdy, o1_rdy, o0_hit, o1_hit, o0_busy, o1_busy;
   logic [12:0]  o0_ma, o1_ma;
   logic [127:0] mem0, mem1;
   logic [15:0]  o0_hc, o0_mc;
   logic [1:0]   o1_hc, o1_mc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // MainMemory contents: word (1024+i) holds i.
   function automatic logic [31:0] mw(input logic [14:0] a);
      return 32'(a) - 32'd1024;
   endfunction

   assign mem0 = {mw({o0_ma, 2'd0}), mw({o0_ma, 2'd1}), mw({o0_ma, 2'd2}), mw({o0_ma, 2'd3})};
   assign mem1 = {mw({o1_ma, 2'd0}), mw({o1_ma, 2'd1}), mw({o1_ma, 2'd2}), mw({o1_ma, 2'd3})};

   direct_mapped_cache_ctrl u_dut (
      .clk(clk), .rst(rst), .cpuReq(req0), .cpuAddress(addr0),
      .cpuData(o0_dat), .cpuReady(o0_rdy), .cpuHit(o0_hit), .busy(o0_busy),
      .memAddress(o0_ma), .memData(mem0), .hitCount(o0_hc), .missCount(o0_mc)
   );

   direct_mapped_cache_ctrl #(.INDEX_BITS(10), .MEM_LATENCY(1), .COUNT_WIDTH(2)) u_wrap (
      .clk(clk), .rst(rst), .cpuReq(req1), .cpuAddress(addr1),
      .cpuData(o1_dat), .cpuReady(o1_rdy), .cpuHit(o1_hit), .busy(o1_busy),
      .memAddress(o1_ma), .memData(mem1), .hitCount(o1_hc), .missCount(o1_mc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request; lat = edges after the request edge until cpuReady is seen.
   task automatic do_req(input bit which, input logic [14:0] a,
                         output int lat, output logic [31:0] d, output logic h);
      logic rdy;
      @(negedge clk);
      if (which) begin req1 = 1'b1; addr1 = a; end
      else       begin req0 = 1'b1; addr0 = a; end
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      lat  = 0;
      forever begin
         @(posedge clk);
         lat++;
         #1;
         rdy = which ? o1_rdy : o0_rdy;
         if (rdy) break;
         if (lat >= 300) begin
            chk("timeout", 32'(rdy), 32'd1);
            break;
         end
      end
      d = which ? o1_dat : o0_dat;
      h = which ? o1_hit : o0_hit;
   endtask

   initial begin
      int          lat;
      logic [31:0] d;
      logic        h;
      int          n_rdy, first_k, busy_low;
      logic        busy_k7, rdy_k9, hit_k9;
      logic [31:0] dat_k6;

      repeat (3) @(negedge clk);
      chk("rst_data",  o0_dat, 32'h0);
      chk("rst_ready", 32'(o0_rdy), 32'd0);
      chk("rst_hit",   32'(o0_hit), 32'd0);
      chk("rst_busy",  32'(o0_busy), 32'd0);
      chk("rst_memaddr", 32'(o0_ma), 32'h0);
      chk("rst_hitcnt",  32'(o0_hc), 32'h0);
      chk("rst_misscnt", 32'(o0_mc), 32'h0);
      rst = 1'b0;

      // Cold miss, then hits in the refilled line.
      do_req(1'b0, 15'h0400, lat, d, h);
      chk("miss0_lat", 32'(lat), 32'd6);
      chk("miss0_data", d, 32'h0);
      chk("miss0_hit", 32'(h), 32'd0);
      chk("miss0_memaddr", 32'(o0_ma), 32'h0100);
      chk("miss0_misscnt", 32'(o0_mc), 32'd1);

      do_req(1'b0, 15'h0401, lat, d, h);
      chk("hit1_lat", 32'(lat), 32'd2);
      chk("hit1_data", d, 32'h1);
      chk("hit1_hit", 32'(h), 32'd1);
      chk("hit1_hitcnt", 32'(o0_hc), 32'd1);

      do_req(1'b0, 15'h0403, lat, d, h);
      chk("hit3_data", d, 32'h3);
      chk("hit3_hitcnt", 32'(o0_hc), 32'd2);

      // Conflict at the same index evicts, and evicts back.
      do_req(1'b0, 15'h1400, lat, d, h);
      chk("conf_lat", 32'(lat), 32'd6);
      chk("conf_data", d, 32'h1000);
      chk("conf_hit", 32'(h), 32'd0);
      chk("conf_memaddr", 32'(o0_ma), 32'h0500);
      chk("conf_misscnt", 32'(o0_mc), 32'd2);
      do_req(1'b0, 15'h0400, lat, d, h);
      chk("back_lat", 32'(lat), 32'd6);
      chk("back_data", d, 32'h0);
      chk("back_misscnt", 32'(o0_mc), 32'd3);

      // cpuReq held high across a miss: one response, next accept on the cpuReady edge.
      @(negedge clk);
      req0 = 1'b1; addr0 = 15'h0802;
      @(posedge clk);
      n_rdy = 0; first_k = 0; busy_low = 0;
      busy_k7 = 1'b0; rdy_k9 = 1'b0; hit_k9 = 1'b0; dat_k6 = '0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (k <= 5 && !o0_busy) busy_low++;
         if (k == 6) dat_k6 = o0_dat;
         if (k == 7) busy_k7 = o0_busy;
         if (k <= 8 && o0_rdy) begin
            n_rdy++;
            if (first_k == 0) first_k = k;
         end
         if (k == 9) begin rdy_k9 = o0_rdy; hit_k9 = o0_hit; end
      end
      req0 = 1'b0;
      chk("hold_resp_count", 32'(n_rdy), 32'd1);
      chk("hold_resp_edge", 32'(first_k), 32'd6);
      chk("hold_data", dat_k6, 32'h402);
      chk("hold_busy_low", 32'(busy_low), 32'd0);
      chk("hold_busy_reaccept", 32'(busy_k7), 32'd1);
      chk("hold_second_rdy", 32'(rdy_k9), 32'd1);
      chk("hold_second_hit", 32'(hit_k9), 32'd1);
      chk("hold_hitcnt", 32'(o0_hc), 32'd3);

      // Reset in the middle of FETCH.
      @(negedge clk);
      req0 = 1'b1; addr0 = 15'h0C01;
      @(posedge clk);
      #1 req0 = 1'b0;
      repeat (4) @(posedge clk);
      chk("prerst_busy", 32'(o0_busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(o0_busy), 32'd0);
      chk("midrst_hitcnt", 32'(o0_hc), 32'd0);
      chk("midrst_misscnt", 32'(o0_mc), 32'd0);
      chk("midrst_data", o0_dat, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_rdy = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o0_rdy) n_rdy++;
      end
      chk("no_ready_after_rst", 32'(n_rdy), 32'd0);
      do_req(1'b0, 15'h0400, lat, d, h);
      chk("postrst_lat", 32'(lat), 32'd6);
      chk("postrst_hit", 32'(h), 32'd0);
      chk("postrst_misscnt", 32'(o0_mc), 32'd1);
      chk("postrst_hitcnt", 32'(o0_hc), 32'd0);
      do_req(1'b0, 15'h0C01, lat, d, h);
      chk("abandoned_lat", 32'(lat), 32'd6);
      chk("abandoned_data", d, 32'h801);

      // Short-latency instance: miss after 3 edges, then hit counter wraps 3 -> 0.
      do_req(1'b1, 15'h0405, lat, d, h);
      chk("l1_miss_lat", 32'(lat), 32'd3);
      chk("l1_miss_data", d, 32'h5);
      chk("l1_misscnt", 32'(o1_mc), 32'd1);
      do_req(1'b1, 15'h0406, lat, d, h);
      do_req(1'b1, 15'h0407, lat, d, h);
      do_req(1'b1, 15'h0404, lat, d, h);
      chk("l1_hit_data", d, 32'h4);
      chk("l1_hitcnt_max", 32'(o1_hc), 32'd3);
      do_req(1'b1, 15'h0405, lat, d, h);
      chk("l1_hit_lat", 32'(lat), 32'd2);
      chk("l1_hit_flag", 32'(h), 32'd1);
      chk("l1_hitcnt_wrap", 32'(o1_hc), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
